lifo_stack_ctrl: RTL and testbench
==================================

Name: lifo_stack_ctrl

Overview:
Parametrised LIFO stack, the next generation of the Fibonacci datapath's operand stack. Adds configurable width and depth, full/empty/count status, atomic replace-top (push+pop in one cycle), a second indexed peek port so the datapath can read top and top-1 together, synchronous clear, and sticky overflow/underflow error flags. Sits between the Fibonacci controller FSM and the adder datapath.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 32, number of entries; must be a power of two and at least 2
AW, $clog2(DEPTH), address width; derived, not overridden

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
din  in  WIDTH  write data for push or replace
push  in  1  push request
pop  in  1  pop request
clear  in  1  synchronous flush of stack and error flags
peek_idx  in  AW  depth below top for the peek port; 0 = top
dout  out  WIDTH  current top entry, combinational
peek_data  out  WIDTH  entry at top-peek_idx, combinational
peek_valid  out  1  peek_idx < count
count  out  AW+1  number of stored entries, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
overflow  out  1  sticky: push was refused while full
underflow  out  1  sticky: pop was refused while empty

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset: count=0, overflow=0, underflow=0. Memory contents are not reset. All outputs settle to empty=1, full=0, dout=0, peek_data=0, peek_valid=0.
- Write pointer is count[AW-1:0]. The top entry is at mem[count-1].
- Per-cycle operation priority is clear > replace > push > pop.
  - clear: count<=0, overflow<=0, underflow<=0. push and pop are ignored that cycle.
  - push&pop, count>0: mem[count-1]<=din. count is unchanged. This holds even when full; no flag is set.
  - push&pop, count==0: acts as a plain push. mem[0]<=din, count<=1, no flag set.
  - push only, not full: mem[count]<=din, count<=count+1.
  - push only, full: no write, count unchanged, overflow<=1.
  - pop only, not empty: count<=count-1. Memory is untouched.
  - pop only, empty: count unchanged, underflow<=1.
- dout = mem[count-1] when count>0, else 0. It is combinational from registered state, so a value pushed at edge N is visible after edge N.
- peek_data = mem[count-1-peek_idx] when peek_valid, else 0. peek_idx=0 equals dout.
- Error flags hold until clear or rst.
- count arithmetic is AW+1 bits and never wraps: 0 <= count <= DEPTH at all times.
- rst asserted mid-operation aborts any in-flight write. State is empty on the next edge after deassertion.

Decomposition:
- Shared package/header lifo_stack_pkg holds:
  - local op encodings OP_NONE, OP_PUSH, OP_POP, OP_REPL, OP_CLR, decoded from clear/push/pop.
  - the clog2-derived AW helper.
- Sub-module lifo_stack_mem: DEPTH x WIDTH register file with one synchronous write port and two asynchronous read ports (top, peek). The controller holds count, flags and op decode only.

Test Plan:
All scenarios use WIDTH=8, DEPTH=4.
- Reset then idle -> count=0, empty=1, full=0, dout=0, peek_valid=0, overflow=underflow=0.
- Push 0x11,0x22,0x33,0x44 -> full=1, count=4, dout=0x44. peek_idx=3 gives 0x11, valid=1. A 5th push of 0x55 leaves dout=0x44 and sets overflow=1.
- From full, push&pop with din=0x99 -> count stays 4, dout=0x99, peek_idx=1 gives 0x33, overflow unchanged.
- Pop four times -> dout sequence 0x33,0x22,0x11 then 0. empty=1 after the 4th pop. A 5th pop sets underflow=1 and count stays 0.
- On an empty stack, push&pop with din=0x5A -> count=1, dout=0x5A, no flags. Then clear -> count=0 and both flags drop to 0.
- Push 0x01,0x02, then assert rst asynchronously mid-cycle with push=1 -> count=0 immediately and no write takes effect. Outputs remain empty until the first push after deassertion.

Source files
------------

// File: rtl/lifo_stack_pkg.sv
// Shared definitions for the LIFO operand stack: operation encodings,
// the op decoder and the address-width helper.
package lifo_stack_pkg;

  // One operation per cycle, decoded from clear/push/pop by priority.
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_REPL = 3'd3,
    OP_CLR  = 3'd4
  } op_e;

  // Address width for a power-of-two depth of at least 2.
  function automatic int calc_aw(input int depth);
    return $clog2(depth);
  endfunction

  // Priority clear > replace > push > pop. A push+pop on an empty stack
  // has no top to replace, so it degrades to a plain push.
  function automatic op_e decode_op(input logic clear,
                                    input logic push,
                                    input logic pop,
                                    input logic empty);
    if (clear)              return OP_CLR;
    if (push && pop)        return empty ? OP_PUSH : OP_REPL;
    if (push)               return OP_PUSH;
    if (pop)                return OP_POP;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/lifo_stack_ctrl_if.sv
// Request/status bundle between the Fibonacci controller (master) and
// the operand stack (slave).
interface lifo_stack_ctrl_if
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
);

  localparam int AW = calc_aw(DEPTH);

  logic [WIDTH-1:0] din;
  logic             push;
  logic             pop;
  logic             clear;
  logic [AW-1:0]    peek_idx;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] peek_data;
  logic             peek_valid;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output din, push, pop, clear, peek_idx,
    input  dout, peek_data, peek_valid, count, empty, full, overflow, underflow
  );

  modport slave (
    input  din, push, pop, clear, peek_idx,
    output dout, peek_data, peek_valid, count, empty, full, overflow, underflow
  );

endinterface

// File: rtl/lifo_stack_mem.sv
// DEPTH x WIDTH register file: one synchronous write port and two
// asynchronous read ports (top of stack and peek).
module lifo_stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_top,
  input  logic [AW-1:0]    raddr_peek,
  output logic [WIDTH-1:0] rdata_top,
  output logic [WIDTH-1:0] rdata_peek
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write; entries above count are never observed, so stale data is harmless.
  // NOTE: the array has no reset on purpose -- resetting it would turn the
  // register file into DEPTH*WIDTH reset flops and block RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_top  = mem[raddr_top];
  assign rdata_peek = mem[raddr_peek];

endmodule

// File: rtl/lifo_stack_ctrl.sv
// LIFO operand stack controller: holds count and the sticky error flags,
// decodes the per-cycle operation and drives the register file.
module lifo_stack_ctrl
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  lifo_stack_ctrl_if.slave  bus
);

  localparam int          AW        = calc_aw(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [AW:0]      count_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             empty;
  logic             full;
  op_e              op;
  logic             we;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    peek_addr;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] rdata_top;
  logic [WIDTH-1:0] rdata_peek;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);

  // Top entry sits one below the write pointer; it wraps when empty but is masked then.
  assign top_addr  = count_q[AW-1:0] - AW'(1);
  assign peek_addr = top_addr - bus.peek_idx;

  // Decode the operation and derive the write strobe and address.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    op    = decode_op(bus.clear, bus.push, bus.pop, empty);
    we    = 1'b0;
    waddr = count_q[AW-1:0];
    unique case (op)
      OP_REPL: begin
        we    = 1'b1;
        waddr = top_addr;
      end
      OP_PUSH: we = !full;
      default: ;
    endcase
    // A write racing an asserted reset is aborted.
    if (rst) we = 1'b0;
  end

  // Count and sticky error flags; clear and rst both return to empty.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      unique case (op)
        OP_CLR: begin
          count_q     <= '0;
          overflow_q  <= 1'b0;
          underflow_q <= 1'b0;
        end
        OP_PUSH: begin
          if (full) overflow_q <= 1'b1;
          else      count_q    <= count_q + (AW+1)'(1);
        end
        OP_POP: begin
          if (empty) underflow_q <= 1'b1;
          else       count_q     <= count_q - (AW+1)'(1);
        end
        default: ;
      endcase
    end
  end

  lifo_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk        (clk),
    .we         (we),
    .waddr      (waddr),
    .wdata      (bus.din),
    .raddr_top  (top_addr),
    .raddr_peek (peek_addr),
    .rdata_top  (rdata_top),
    .rdata_peek (rdata_peek)
  );

  assign bus.peek_valid = ({1'b0, bus.peek_idx} < count_q);
  assign bus.dout       = empty ? '0 : rdata_top;
  assign bus.peek_data  = bus.peek_valid ? rdata_peek : '0;
  assign bus.count      = count_q;
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// Directed bench for lifo_stack_ctrl with WIDTH=8, DEPTH=4.
module tb_lifo_stack_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  lifo_stack_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  lifo_stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one request for one edge, then sample 1ns after that edge.
  task automatic op(input logic p, input logic q, input logic c, input logic [7:0] d);
    bus.push  = p;
    bus.pop   = q;
    bus.clear = c;
    bus.din   = d;
    @(posedge clk);
    #1;
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.clear = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.clear = 1'b0;
    bus.din = '0; bus.peek_idx = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset then idle
    check("rst_count",     32'(bus.count),      0);
    check("rst_empty",     32'(bus.empty),      1);
    check("rst_full",      32'(bus.full),       0);
    check("rst_dout",      32'(bus.dout),       0);
    check("rst_pvalid",    32'(bus.peek_valid), 0);
    check("rst_pdata",     32'(bus.peek_data),  0);
    check("rst_overflow",  32'(bus.overflow),   0);
    check("rst_underflow", 32'(bus.underflow),  0);

    // Fill the stack
    op(1, 0, 0, 8'h11); check("push1_dout", 32'(bus.dout), 32'h11);
    op(1, 0, 0, 8'h22); check("push2_dout", 32'(bus.dout), 32'h22);
    op(1, 0, 0, 8'h33); check("push3_dout", 32'(bus.dout), 32'h33);
    op(1, 0, 0, 8'h44);
    check("full_flag",  32'(bus.full),  1);
    check("full_count", 32'(bus.count), 4);
    check("full_dout",  32'(bus.dout),  32'h44);
    check("full_empty", 32'(bus.empty), 0);
    bus.peek_idx = 2'd0; #1;
    check("peek0_data",  32'(bus.peek_data),  32'h44);
    bus.peek_idx = 2'd3; #1;
    check("peek3_data",  32'(bus.peek_data),  32'h11);
    check("peek3_valid", 32'(bus.peek_valid), 1);

    // Push into a full stack
    op(1, 0, 0, 8'h55);
    check("ovf_dout",  32'(bus.dout),     32'h44);
    check("ovf_count", 32'(bus.count),    4);
    check("ovf_flag",  32'(bus.overflow), 1);

    // Replace top while full
    op(1, 1, 0, 8'h99);
    check("repl_count", 32'(bus.count),    4);
    check("repl_dout",  32'(bus.dout),     32'h99);
    check("repl_ovf",   32'(bus.overflow), 1);
    bus.peek_idx = 2'd1; #1;
    check("repl_peek1", 32'(bus.peek_data), 32'h33);

    // Drain
    op(0, 1, 0, 8'h00); check("pop1_dout", 32'(bus.dout), 32'h33);
    check("pop1_peek1", 32'(bus.peek_data), 32'h22);
    op(0, 1, 0, 8'h00); check("pop2_dout", 32'(bus.dout), 32'h22);
    op(0, 1, 0, 8'h00); check("pop3_dout", 32'(bus.dout), 32'h11);
    check("pop3_pvalid", 32'(bus.peek_valid), 0);
    check("pop3_pdata",  32'(bus.peek_data),  0);
    op(0, 1, 0, 8'h00);
    check("pop4_dout",  32'(bus.dout),      0);
    check("pop4_empty", 32'(bus.empty),     1);
    check("pop4_udf",   32'(bus.underflow), 0);
    op(0, 1, 0, 8'h00);
    check("udf_flag",  32'(bus.underflow), 1);
    check("udf_count", 32'(bus.count),     0);

    // Push+pop on empty acts as push; earlier sticky flags remain
    op(1, 1, 0, 8'h5A);
    check("ep_count", 32'(bus.count),     1);
    check("ep_dout",  32'(bus.dout),      32'h5A);
    check("ep_ovf",   32'(bus.overflow),  1);
    check("ep_udf",   32'(bus.underflow), 1);

    // Clear wins over a simultaneous push
    op(1, 0, 1, 8'h77);
    check("clr_count", 32'(bus.count),     0);
    check("clr_ovf",   32'(bus.overflow),  0);
    check("clr_udf",   32'(bus.underflow), 0);
    check("clr_dout",  32'(bus.dout),      0);

    // Async reset mid-cycle with push held
    op(1, 0, 0, 8'h01);
    op(1, 0, 0, 8'h02);
    check("pre_rst_count", 32'(bus.count), 2);
    bus.push = 1'b1;
    bus.din  = 8'hEE;
    #3 rst = 1'b1;
    #1;
    check("async_rst_count", 32'(bus.count), 0);
    check("async_rst_dout",  32'(bus.dout),  0);
    @(posedge clk); #1;
    check("rst_hold_count", 32'(bus.count), 0);
    rst = 1'b0;
    bus.push = 1'b0;
    @(posedge clk); #1;
    check("post_rst_empty", 32'(bus.empty), 1);
    check("post_rst_dout",  32'(bus.dout),  0);
    op(1, 0, 0, 8'hAB);
    check("post_rst_push_count", 32'(bus.count), 1);
    check("post_rst_push_dout",  32'(bus.dout),  32'hAB);
    bus.peek_idx = 2'd1; #1;
    check("post_rst_peek1_valid", 32'(bus.peek_valid), 0);
    check("post_rst_peek1_data",  32'(bus.peek_data),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net in case the clock or stimulus stalls.
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
